// File: rtl/gdiv_pkg.sv
// Shared types for the Goldschmidt divider control path:
// FSM states, multiplier select codes and the steering bundle.
package gdiv_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CAP,
        S_INITQ,
        S_INITD,
        S_INITK,
        S_MULQ,
        S_MULD,
        S_MULK,
        S_DONE
    } gdiv_state_t;

    localparam logic [2:0] MA_N = 3'd0;
    localparam logic [2:0] MA_D = 3'd1;
    localparam logic [2:0] MA_A = 3'd2;
    localparam logic [2:0] MA_B = 3'd3;

    localparam logic [1:0] MB_K0  = 2'd0;
    localparam logic [1:0] MB_K   = 2'd1;
    localparam logic [1:0] MB_ONE = 2'd2;

    typedef struct packed {
        logic       sn;
        logic       sd;
        logic [2:0] ma;
        logic [1:0] mb;
        logic       ms;
        logic       la;
        logic       lb;
        logic       lk;
    } ctrl_t;

endpackage

// File: rtl/gdiv_ctrl.sv
// Goldschmidt divider sequencer: seed, ITERS refinement passes, done.
// Optional divide-by-zero early exit under GDIV_ZERO_DET_EN.
module gdiv_ctrl
    import gdiv_pkg::*;
#(
    parameter int ITERS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       d_zero,
    output logic       Sn,
    output logic       Sd,
    output logic [2:0] Ma,
    output logic [1:0] Mb,
    output logic       Ms,
    output logic       La,
    output logic       Lb,
    output logic       Lk,
    output logic       busy,
    output logic       done,
    output logic       dz
);

    localparam int CW = $clog2(ITERS + 1);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    gdiv_state_t   state, nxt;
    logic [CW-1:0] cnt;
    ctrl_t         c;
    logic          zero_exit;

`ifdef GDIV_ZERO_DET_EN
    logic dz_q;

    assign zero_exit = d_zero;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dz_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            dz_q <= 1'b0;
        end else if (state == S_CAP && d_zero) begin
            dz_q <= 1'b1;
        end
    end

    // Flag is held internally but only presented alongside done
    assign dz = dz_q && (state == S_DONE);
`else
    logic unused_d_zero;

    assign unused_d_zero = d_zero;
    assign zero_exit     = 1'b0;
    assign dz            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && start) begin
                cnt <= '0;
            end else if (state == S_MULK) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        nxt  = state;
        c    = '0;
        busy = 1'b1;
        done = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) nxt = S_CAP;
            end
            S_CAP: begin
                c.sn = 1'b1;
                c.sd = 1'b1;
                nxt  = zero_exit ? S_DONE : S_INITQ;
            end
            S_INITQ: begin
                c.ma = MA_N;
                c.mb = MB_K0;
                c.la = 1'b1;
                nxt  = S_INITD;
            end
            S_INITD: begin
                c.ma = MA_D;
                c.mb = MB_K0;
                c.lb = 1'b1;
                nxt  = S_INITK;
            end
            S_INITK: begin
                c.ms = 1'b1;
                c.lk = 1'b1;
                nxt  = S_MULQ;
            end
            S_MULQ: begin
                c.ma = MA_A;
                c.mb = MB_K;
                c.la = 1'b1;
                nxt  = S_MULD;
            end
            S_MULD: begin
                c.ma = MA_B;
                c.mb = MB_K;
                c.lb = 1'b1;
                // Final pass needs no new K, so it skips MULK
                nxt  = (cnt < LAST) ? S_MULK : S_DONE;
            end
            S_MULK: begin
                c.ms = 1'b1;
                c.lk = 1'b1;
                nxt  = S_MULQ;
            end
            S_DONE: begin
                done = 1'b1;
                nxt  = S_IDLE;
            end
            default: begin
                busy = 1'b0;
                nxt  = S_IDLE;
            end
        endcase
    end

    assign Sn = c.sn;
    assign Sd = c.sd;
    assign Ma = c.ma;
    assign Mb = c.mb;
    assign Ms = c.ms;
    assign La = c.la;
    assign Lb = c.lb;
    assign Lk = c.lk;

endmodule

// File: tb/tb_gdiv_ctrl.sv
// Directed scoreboard bench for gdiv_ctrl (ITERS=3).
// Expected per-cycle output vectors are queued at start, popped each cycle.
module tb_gdiv_ctrl;

    localparam int ITERS = 3;
    localparam int LAST  = 3 * ITERS + 4;

    typedef logic [13:0] vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       d_zero;
    logic       Sn, Sd, Ms, La, Lb, Lk, busy, done, dz;
    logic [2:0] Ma;
    logic [1:0] Mb;

    int   tests = 0;
    int   fails = 0;
    int   la_cnt, lb_cnt, lk_cnt, done_cnt;
    vec_t q[$];

    gdiv_ctrl #(.ITERS(ITERS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .d_zero(d_zero),
        .Sn    (Sn),
        .Sd    (Sd),
        .Ma    (Ma),
        .Mb    (Mb),
        .Ms    (Ms),
        .La    (La),
        .Lb    (Lb),
        .Lk    (Lk),
        .busy  (busy),
        .done  (done),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    // Cycle k counts from the edge that accepted start; k=0 means idle
    function automatic vec_t model(int k, bit zero);
        logic       b, d, z, sn, sd, ms, la, lb, lk;
        logic [2:0] ma;
        logic [1:0] mb;
        {b, d, z, sn, sd, ms, la, lb, lk} = '0;
        ma = '0;
        mb = '0;
        if (k >= 1) b = 1'b1;
        if (k == 1) begin
            sn = 1'b1;
            sd = 1'b1;
        end else if (zero) begin
            if (k == 2) begin
                d = 1'b1;
                z = 1'b1;
            end
        end else if (k == LAST) begin
            d = 1'b1;
        end else if (k == 2) begin
            la = 1'b1;
        end else if (k == 3) begin
            ma = 3'd1;
            lb = 1'b1;
        end else if (k == 4) begin
            ms = 1'b1;
            lk = 1'b1;
        end else if (k >= 5) begin
            case ((k - 5) % 3)
                0: begin ma = 3'd2; mb = 2'd1; la = 1'b1; end
                1: begin ma = 3'd3; mb = 2'd1; lb = 1'b1; end
                default: begin ms = 1'b1; lk = 1'b1; end
            endcase
        end
        return {b, d, z, sn, sd, ma, mb, ms, la, lb, lk};
    endfunction

    function automatic vec_t observed();
        return {busy, done, dz, Sn, Sd, Ma, Mb, Ms, La, Lb, Lk};
    endfunction

    task automatic push_run(bit zero);
        int n;
        n = zero ? 2 : LAST;
        for (int k = 1; k <= n; k++) q.push_back(model(k, zero));
    endtask

    task automatic check_val(string tag, int obs, int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Each cycle: sample at negedge, compare against queue head, then drive
    task automatic run(int n, logic s, logic r);
        vec_t exp, obs;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs = observed();
            tests++;
            if (q.size() == 0) begin
                fails++;
                $error("FAIL scoreboard_empty observed=%h", obs);
            end else begin
                exp = q.pop_front();
                assert (obs === exp) else begin
                    fails++;
                    $error("FAIL vec t=%0t observed=%h expected=%h",
                           $time, obs, exp);
                end
            end
            la_cnt   += int'(La);
            lb_cnt   += int'(Lb);
            lk_cnt   += int'(Lk);
            done_cnt += int'(done);
            start = s;
            rst_n = r;
        end
    endtask

    task automatic clr_counts();
        la_cnt   = 0;
        lb_cnt   = 0;
        lk_cnt   = 0;
        done_cnt = 0;
    endtask

    initial begin
        clr_counts();
        rst_n  = 1'b0;
        start  = 1'b1;
        d_zero = 1'b0;

        // Reset held two cycles with start asserted
        @(posedge clk);
        q.push_back(model(0, 0));
        q.push_back(model(0, 0));
        run(1, 1'b1, 1'b0);
        run(1, 1'b0, 1'b1);
        q.push_back(model(0, 0));
        run(1, 1'b0, 1'b1);

        // Single start pulse
        clr_counts();
        start = 1'b1;
        push_run(0);
        q.push_back(model(0, 0));
        run(1, 1'b0, 1'b1);
        run(LAST, 1'b0, 1'b1);
        check_val("la_count", la_cnt, 4);
        check_val("lb_count", lb_cnt, 4);
        check_val("lk_count", lk_cnt, 3);
        check_val("done_count", done_cnt, 1);

        // start held high: second run after one idle cycle
        clr_counts();
        start = 1'b1;
        push_run(0);
        q.push_back(model(0, 0));
        push_run(0);
        q.push_back(model(0, 0));
        run(LAST + 2, 1'b1, 1'b1);
        run(LAST - 1, 1'b0, 1'b1);
        run(1, 1'b0, 1'b1);
        check_val("held_done_count", done_cnt, 2);

        // Reset asserted in cycle 6 aborts the run
        clr_counts();
        start = 1'b1;
        for (int k = 1; k <= 6; k++) q.push_back(model(k, 0));
        q.push_back(model(0, 0));
        q.push_back(model(0, 0));
        run(5, 1'b0, 1'b1);
        run(1, 1'b0, 1'b0);
        run(1, 1'b0, 1'b1);
        run(1, 1'b0, 1'b1);
        check_val("abort_done_count", done_cnt, 0);

        clr_counts();
        start = 1'b1;
        push_run(0);
        q.push_back(model(0, 0));
        run(LAST + 1, 1'b0, 1'b1);
        check_val("rerun_done_count", done_cnt, 1);
        check_val("rerun_la_count", la_cnt, 4);

`ifdef GDIV_ZERO_DET_EN
        // Divide by zero: done with dz in cycle 2, no loads
        clr_counts();
        d_zero = 1'b1;
        start  = 1'b1;
        push_run(1);
        q.push_back(model(0, 0));
        run(3, 1'b0, 1'b1);
        check_val("dz_loads", la_cnt + lb_cnt + lk_cnt, 0);
        check_val("dz_done_count", done_cnt, 1);

        clr_counts();
        d_zero = 1'b0;
        start  = 1'b1;
        push_run(0);
        q.push_back(model(0, 0));
        run(LAST + 1, 1'b0, 1'b1);
        check_val("nz_lk_count", lk_cnt, 3);
`endif

        check_val("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
